// File: rtl/mem_arbiter.sv
// Memory sequencer shared by the I-cache and D-cache miss paths: pipelined block fills and
// single-word write-through stores, with alternating priority when both caches ask at once.
module mem_arbiter #(
    parameter int MEM_LAT       = 4,
    parameter int WORDS_PER_BLK = 8,
    parameter int WIDX_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [15:0]       ic_addr,
    input  logic              dc_req,
    input  logic              dc_wr,
    input  logic [15:0]       dc_addr,
    input  logic [15:0]       dc_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [15:0]       fill_data,
    output logic [WIDX_W-1:0] fill_widx,
    output logic              ic_fill_we,
    output logic              dc_fill_we,
    output logic              ic_done,
    output logic              dc_done,
    output logic              busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_IC_FILL  = 3'd1;
    localparam logic [2:0] S_DC_FILL  = 3'd2;
    localparam logic [2:0] S_DC_WRITE = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [WIDX_W:0] BLK_WORDS = (WIDX_W + 1)'(WORDS_PER_BLK);
    localparam logic [WIDX_W:0] LAST_IDX  = (WIDX_W + 1)'(WORDS_PER_BLK - 1);
    localparam logic [WIDX_W:0] CNT_ONE   = (WIDX_W + 1)'(1);
    localparam logic [15:0]     OFS_MASK  = 16'((1 << (WIDX_W + 1)) - 1);

    generate
        if (MEM_LAT < 1 || WORDS_PER_BLK < 2 || (1 << WIDX_W) != WORDS_PER_BLK) begin : g_param_err
            $error("mem_arbiter: illegal parameter combination");
        end
    endgenerate

    logic [2:0]        state_q, state_d;
    logic [WIDX_W:0]   iss_q, iss_d;
    logic [WIDX_W:0]   rcv_q, rcv_d;
    logic              last_dc_q, last_dc_d;
    logic              owner_dc_q, owner_dc_d;
    logic [15:0]       base_q, base_d;
    logic [15:0]       wdata_q, wdata_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [15:0]       mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              ic_done_q, ic_done_d;
    logic              dc_done_q, dc_done_d;
    logic              busy_q, busy_d;

    logic              in_fill_s;
    logic              fill_next_s;
    logic              rvalid_ok_s;

    // A return is only accepted in a fill state and only while an issued read is still outstanding.
    assign in_fill_s   = (state_q == S_IC_FILL) || (state_q == S_DC_FILL);
    assign rvalid_ok_s = in_fill_s && mem_rvalid && (rcv_q < iss_q);

    // Next-state, counters, arbitration and captured transaction context.
    always_comb begin
        state_d    = state_q;
        iss_d      = iss_q;
        rcv_d      = rcv_q;
        last_dc_d  = last_dc_q;
        owner_dc_d = owner_dc_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (dc_req && (!ic_req || !last_dc_q)) begin
                    owner_dc_d = 1'b1;
                    last_dc_d  = 1'b1;
                    iss_d      = '0;
                    rcv_d      = '0;
                    if (dc_wr) begin
                        base_d  = {dc_addr[15:1], 1'b0};
                        wdata_d = dc_wdata;
                        state_d = S_DC_WRITE;
                    end else begin
                        base_d  = dc_addr & ~OFS_MASK;
                        state_d = S_DC_FILL;
                    end
                end else if (ic_req) begin
                    owner_dc_d = 1'b0;
                    last_dc_d  = 1'b0;
                    iss_d      = '0;
                    rcv_d      = '0;
                    base_d     = ic_addr & ~OFS_MASK;
                    state_d    = S_IC_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IC_FILL, S_DC_FILL: begin
                if (iss_q < BLK_WORDS) begin
                    iss_d = iss_q + CNT_ONE;
                end else begin
                    iss_d = iss_q;
                end
                if (rvalid_ok_s) begin
                    rcv_d = rcv_q + CNT_ONE;
                    if (rcv_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    rcv_d = rcv_q;
                end
            end
            S_DC_WRITE: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Memory command and status outputs are registered from the next-state view.
    always_comb begin
        fill_next_s = (state_d == S_IC_FILL) || (state_d == S_DC_FILL);
        mem_en_d    = (fill_next_s && (iss_d < BLK_WORDS)) || (state_d == S_DC_WRITE);
        mem_wr_d    = (state_d == S_DC_WRITE);
        if (state_d == S_DC_WRITE) begin
            mem_addr_d  = base_d;
            mem_wdata_d = wdata_d;
        end else if (mem_en_d) begin
            mem_addr_d  = {base_d[15:WIDX_W+1], iss_d[WIDX_W-1:0], 1'b0};
            mem_wdata_d = 16'h0000;
        end else begin
            mem_addr_d  = 16'h0000;
            mem_wdata_d = 16'h0000;
        end
        ic_done_d = (state_d == S_DONE) && !owner_dc_d;
        dc_done_d = (state_d == S_DONE) && owner_dc_d;
        busy_d    = (state_d != S_IDLE);
    end

    // Control state; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            iss_q      <= '0;
            rcv_q      <= '0;
            last_dc_q  <= 1'b0;
            owner_dc_q <= 1'b0;
            base_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            iss_q      <= iss_d;
            rcv_q      <= rcv_d;
            last_dc_q  <= last_dc_d;
            owner_dc_q <= owner_dc_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_done_q   <= ic_done_d;
            dc_done_q   <= dc_done_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign ic_done    = ic_done_q;
    assign dc_done    = dc_done_q;
    assign busy       = busy_q;
    assign fill_data  = mem_rdata;
    assign fill_widx  = rcv_q[WIDX_W-1:0];
    assign ic_fill_we = rvalid_ok_s && !owner_dc_q;
    assign dc_fill_we = rvalid_ok_s && owner_dc_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: an 8-word/latency-4 instance and a 4-word/latency-2 instance
// share one pipelined memory model; expected commands, fills and done pulses are queued by stimulus.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Cycle index of the current clock period.
    always @(posedge clk) cyc <= cyc + 1;

    logic        sel = 1'b0;
    logic        ic_req = 1'b0, dc_req = 1'b0, dc_wr = 1'b0;
    logic [15:0] ic_addr = 16'h0, dc_addr = 16'h0, dc_wdata = 16'h0;

    logic        a_mem_en, a_mem_wr, a_icwe, a_dcwe, a_icd, a_dcd, a_busy;
    logic [15:0] a_mem_addr, a_mem_wdata, a_fdata;
    logic [2:0]  a_widx;
    logic        b_mem_en, b_mem_wr, b_icwe, b_dcwe, b_icd, b_dcd, b_busy;
    logic [15:0] b_mem_addr, b_mem_wdata, b_fdata;
    logic [1:0]  b_widx;

    logic        pv [0:3];
    logic [15:0] pa [0:3];

    function automatic logic [15:0] rd_of(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    mem_arbiter #(.MEM_LAT(4), .WORDS_PER_BLK(8), .WIDX_W(3)) u_dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req & ~sel), .ic_addr(ic_addr),
        .dc_req(dc_req & ~sel), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .mem_en(a_mem_en), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(rd_of(pa[3])), .mem_rvalid(pv[3]),
        .fill_data(a_fdata), .fill_widx(a_widx), .ic_fill_we(a_icwe), .dc_fill_we(a_dcwe),
        .ic_done(a_icd), .dc_done(a_dcd), .busy(a_busy)
    );

    mem_arbiter #(.MEM_LAT(2), .WORDS_PER_BLK(4), .WIDX_W(2)) u_dut4 (
        .clk(clk), .rst(rst),
        .ic_req(ic_req & sel), .ic_addr(ic_addr),
        .dc_req(dc_req & sel), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(rd_of(pa[1])), .mem_rvalid(pv[1]),
        .fill_data(b_fdata), .fill_widx(b_widx), .ic_fill_we(b_icwe), .dc_fill_we(b_dcwe),
        .ic_done(b_icd), .dc_done(b_dcd), .busy(b_busy)
    );

    logic        m_en, m_wr, m_icwe, m_dcwe, m_icd, m_dcd, m_busy;
    logic [15:0] m_addr, m_wdata, m_fdata;
    logic [2:0]  m_widx;
    assign m_en    = sel ? b_mem_en    : a_mem_en;
    assign m_wr    = sel ? b_mem_wr    : a_mem_wr;
    assign m_addr  = sel ? b_mem_addr  : a_mem_addr;
    assign m_wdata = sel ? b_mem_wdata : a_mem_wdata;
    assign m_fdata = sel ? b_fdata     : a_fdata;
    assign m_widx  = sel ? {1'b0, b_widx} : a_widx;
    assign m_icwe  = sel ? b_icwe : a_icwe;
    assign m_dcwe  = sel ? b_dcwe : a_dcwe;
    assign m_icd   = sel ? b_icd  : a_icd;
    assign m_dcd   = sel ? b_dcd  : a_dcd;
    assign m_busy  = sel ? b_busy : a_busy;

    // Pipelined memory: a read sampled at the end of cycle c returns in cycle c+2 (pv[1]) or c+4 (pv[3]).
    always @(posedge clk) begin
        pv[0] <= m_en && !m_wr;
        pa[0] <= m_addr;
        for (int i = 1; i < 4; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] data; } cmd_t;
    typedef struct { int cyc; logic dc; logic [2:0] widx; logic [15:0] data; } fill_t;
    typedef struct { int cyc; logic dc; } done_t;
    cmd_t  cmd_q[$];
    fill_t fill_q[$];
    done_t done_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected DUT event at cycle %0d", name, cyc);
    endtask

    task automatic exp_fill(input logic dc, input logic [15:0] base, input int t, input int w, input int l);
        cmd_t c;
        fill_t f;
        done_t d;
        for (int i = 0; i < w; i++) begin
            c.cyc = t + 1 + i; c.wr = 1'b0; c.addr = base + 16'(2 * i); c.data = 16'h0;
            cmd_q.push_back(c);
        end
        for (int i = 0; i < w; i++) begin
            f.cyc = t + 1 + l + i; f.dc = dc; f.widx = 3'(i); f.data = rd_of(base + 16'(2 * i));
            fill_q.push_back(f);
        end
        d.cyc = t + w + l + 1; d.dc = dc;
        done_q.push_back(d);
    endtask

    task automatic exp_store(input logic [15:0] addr, input logic [15:0] data, input int t);
        cmd_t c;
        done_t d;
        c.cyc = t + 1; c.wr = 1'b1; c.addr = addr; c.data = data;
        cmd_q.push_back(c);
        d.cyc = t + 2; d.dc = 1'b1;
        done_q.push_back(d);
    endtask

    // Monitor: compares every command, fill strobe and done pulse against the queued expectations.
    always @(negedge clk) begin
        cmd_t  c;
        fill_t f;
        done_t d;
        if (rst) begin
            if (m_en) begin
                if (cmd_q.size() == 0) unexpected("mem_cmd");
                else begin
                    c = cmd_q.pop_front();
                    chk("cmd_cycle", cyc, c.cyc);
                    chk("cmd_wr", {31'd0, m_wr}, {31'd0, c.wr});
                    chk("cmd_addr", {16'd0, m_addr}, {16'd0, c.addr});
                    if (c.wr) chk("cmd_wdata", {16'd0, m_wdata}, {16'd0, c.data});
                end
            end
            if (m_icwe || m_dcwe) begin
                if (fill_q.size() == 0) unexpected("fill_we");
                else begin
                    f = fill_q.pop_front();
                    chk("fill_cycle", cyc, f.cyc);
                    chk("fill_ic_we", {31'd0, m_icwe}, {31'd0, ~f.dc});
                    chk("fill_dc_we", {31'd0, m_dcwe}, {31'd0, f.dc});
                    chk("fill_widx", {29'd0, m_widx}, {29'd0, f.widx});
                    chk("fill_data", {16'd0, m_fdata}, {16'd0, f.data});
                end
            end
            if (m_icd || m_dcd) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("ic_done", {31'd0, m_icd}, {31'd0, ~d.dc});
                    chk("dc_done", {31'd0, m_dcd}, {31'd0, d.dc});
                    chk("busy_in_done", {31'd0, m_busy}, 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the owner's done pulse and drop its request before the edge that ends DONE.
    task automatic wait_done(input logic dc, input int budget);
        bit found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            tick();
            if (dc ? m_dcd : m_icd) found = 1'b1;
        end
        if (!found) unexpected(dc ? "dc_done_timeout" : "ic_done_timeout");
        if (dc) dc_req = 1'b0;
        else    ic_req = 1'b0;
    endtask

    initial begin
        int t;
        repeat (2) tick();
        chk("rst_mem_en", {31'd0, a_mem_en}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_done", {30'd0, a_icd, a_dcd}, 32'd0);
        chk("rst_widx", {29'd0, a_widx}, 32'd0);
        rst = 1'b1;
        tick();

        // Single I fill, unaligned address.
        t = cyc; ic_addr = 16'h1236; ic_req = 1'b1;
        exp_fill(1'b0, 16'h1230, t, 8, 4);
        wait_done(1'b0, 40);
        tick();

        // Both request, last owner was I: D first, then I in the following IDLE cycle.
        t = cyc; ic_addr = 16'h0A5E; ic_req = 1'b1; dc_addr = 16'h4C2B; dc_wr = 1'b0; dc_req = 1'b1;
        exp_fill(1'b1, 16'h4C20, t, 8, 4);
        exp_fill(1'b0, 16'h0A50, t + 14, 8, 4);
        wait_done(1'b1, 40);
        wait_done(1'b0, 40);
        tick();

        // Single-word store.
        t = cyc; dc_addr = 16'h0043; dc_wdata = 16'hBEEF; dc_wr = 1'b1; dc_req = 1'b1;
        exp_store(16'h0042, 16'hBEEF, t);
        tick();
        chk("store_busy_t1", {31'd0, a_busy}, 32'd1);
        wait_done(1'b1, 10);
        chk("store_busy_t2", {31'd0, a_busy}, 32'd1);
        chk("store_done_cycle", cyc, t + 2);
        dc_wr = 1'b0;
        tick();
        chk("store_busy_idle", {31'd0, a_busy}, 32'd0);

        // Both again, last owner was D: I wins; top-of-memory and zero block bases.
        t = cyc; ic_addr = 16'hFFFE; ic_req = 1'b1; dc_addr = 16'h0000; dc_req = 1'b1;
        exp_fill(1'b0, 16'hFFF0, t, 8, 4);
        exp_fill(1'b1, 16'h0000, t + 14, 8, 4);
        wait_done(1'b0, 40);
        wait_done(1'b1, 40);
        tick();

        // Store request arriving mid-fill waits for IDLE.
        t = cyc; ic_addr = 16'h2222; ic_req = 1'b1;
        exp_fill(1'b0, 16'h2220, t, 8, 4);
        repeat (3) tick();
        dc_addr = 16'h3335; dc_wdata = 16'h1234; dc_wr = 1'b1; dc_req = 1'b1;
        exp_store(16'h3334, 16'h1234, t + 14);
        wait_done(1'b0, 40);
        wait_done(1'b1, 10);
        dc_wr = 1'b0;
        tick();

        // Reset in the middle of a fill, stray returns afterwards, then a clean fill.
        t = cyc; ic_addr = 16'h5550; ic_req = 1'b1;
        exp_fill(1'b0, 16'h5550, t, 8, 4);
        repeat (7) tick();
        rst = 1'b0; ic_req = 1'b0;
        cmd_q.delete(); fill_q.delete(); done_q.delete();
        #1;
        chk("midrst_mem_en", {31'd0, a_mem_en}, 32'd0);
        chk("midrst_busy", {31'd0, a_busy}, 32'd0);
        chk("midrst_fill_we", {30'd0, a_icwe, a_dcwe}, 32'd0);
        chk("midrst_widx", {29'd0, a_widx}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("post_rst_busy", {31'd0, a_busy}, 32'd0);
        t = cyc; ic_addr = 16'h5558; ic_req = 1'b1;
        exp_fill(1'b0, 16'h5550, t, 8, 4);
        wait_done(1'b0, 40);
        tick();

        // Small-block instance: 4 words, latency 2.
        sel = 1'b1;
        tick();
        t = cyc; ic_addr = 16'h8009; ic_req = 1'b1;
        exp_fill(1'b0, 16'h8008, t, 4, 2);
        wait_done(1'b0, 20);
        chk("blk4_done_cycle", cyc, t + 7);
        tick();
        t = cyc; dc_addr = 16'h00FF; dc_wr = 1'b0; dc_req = 1'b1;
        exp_fill(1'b1, 16'h00F8, t, 4, 2);
        wait_done(1'b1, 20);
        repeat (4) tick();

        chk("cmd_queue_empty", cmd_q.size(), 32'd0);
        chk("fill_queue_empty", fill_q.size(), 32'd0);
        chk("done_queue_empty", done_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
